// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the restoring divider.
package div_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // The counter must hold the value WIDTH itself, not just WIDTH-1.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/restore_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract
// the divisor, and either keep the difference or restore the shifted value.
module restore_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           borrow;

  assign shifted = {rem_in, dividend_msb};
  assign diff    = shifted - {1'b0, divisor};
  // The top difference bit is the borrow and doubles as the restore select.
  assign borrow  = diff[WIDTH];

  always_comb begin
    rem_next = diff;
    q_bit    = 1'b1;
    if (borrow) begin
      rem_next = shifted;
      q_bit    = 1'b0;
    end
  end

endmodule

// File: rtl/restoring_divider_seq.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Define DIV_BY_ZERO_FLAG_EN for a one-edge divide-by-zero shortcut and div_zero flag.
module restoring_divider_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_n;
  logic [WIDTH:0]   rem_q, rem_n;
  logic [WIDTH-1:0] sh_q, sh_n;
  logic [WIDTH-1:0] dvs_q, dvs_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic             busy_n, done_n, dz_n;
  logic [WIDTH-1:0] quot_n, remd_n;

  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic             zero_fast;
  logic             unused_rem_msb;

  // Only the low bits feed the next shift; the top bit exists to hold a full difference.
  assign unused_rem_msb = rem_q[WIDTH];

`ifdef DIV_BY_ZERO_FLAG_EN
  assign zero_fast = (divisor == '0);
`else
  assign zero_fast = 1'b0;
`endif

  restore_step #(.WIDTH(WIDTH)) u_step (
    .rem_in       (rem_q[WIDTH-1:0]),
    .dividend_msb (sh_q[WIDTH-1]),
    .divisor      (dvs_q),
    .rem_next     (step_rem),
    .q_bit        (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rem_q     <= '0;
      sh_q      <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      state     <= state_n;
      rem_q     <= rem_n;
      sh_q      <= sh_n;
      dvs_q     <= dvs_n;
      cnt_q     <= cnt_n;
      busy      <= busy_n;
      done      <= done_n;
      quotient  <= quot_n;
      remainder <= remd_n;
      div_zero  <= dz_n;
    end
  end

  // Quotient bits shift into the dividend register as dividend bits shift out.
  always_comb begin
    state_n = state;
    rem_n   = rem_q;
    sh_n    = sh_q;
    dvs_n   = dvs_q;
    cnt_n   = cnt_q;
    busy_n  = busy;
    done_n  = 1'b0;
    quot_n  = quotient;
    remd_n  = remainder;
    dz_n    = div_zero;

    case (state)
      IDLE: begin
        if (start && zero_fast) begin
          quot_n = '1;
          remd_n = dividend;
          dz_n   = 1'b1;
          done_n = 1'b1;
        end else if (start) begin
          sh_n    = dividend;
          rem_n   = '0;
          dvs_n   = divisor;
          cnt_n   = CW'(WIDTH);
          busy_n  = 1'b1;
          dz_n    = 1'b0;
          state_n = RUN;
        end
      end
      RUN: begin
        rem_n = step_rem;
        sh_n  = {sh_q[WIDTH-2:0], step_q};
        cnt_n = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quot_n  = {sh_q[WIDTH-2:0], step_q};
          remd_n  = step_rem[WIDTH-1:0];
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_restoring_divider_seq.sv
// Self-checking bench for restoring_divider_seq (WIDTH=8): vector table,
// handshake corner cases and randomized operands against an arithmetic model.
module tb_restoring_divider_seq;

  localparam int W = 8;
`ifdef DIV_BY_ZERO_FLAG_EN
  localparam bit ZERO_FAST = 1'b1;
`else
  localparam bit ZERO_FAST = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int n_checks = 0;
  int n_pass   = 0;

  restoring_divider_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  vec_t vecs[10];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
  endtask

  // Called at a negedge right after apply_stimulus; returns at the negedge where done is seen.
  task automatic wait_done(output logic [W-1:0] q, output logic [W-1:0] r, output logic dz,
                           output int iters, output int busy_cnt);
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    iters    = 0;
    busy_cnt = 0;
    while (!done && iters < 40) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      iters++;
      @(negedge clk);
    end
    q  = quotient;
    r  = remainder;
    dz = div_zero;
  endtask

  // Reference model: plain integer division with the divide-by-zero convention.
  task automatic check_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] q, input logic [W-1:0] r, input logic dz,
                          input int iters, input int busy_cnt);
    int exp_q, exp_r, exp_it;
    bit exp_dz;
    if (b == 0) begin
      exp_q = (1 << W) - 1;
      exp_r = a;
    end else begin
      exp_q = a / b;
      exp_r = a % b;
    end
    exp_dz = ZERO_FAST && (b == 0);
    exp_it = exp_dz ? 0 : W;
    check_output({tag, " quotient"},  q, exp_q);
    check_output({tag, " remainder"}, r, exp_r);
    check_output({tag, " div_zero"},  dz, exp_dz);
    check_output({tag, " latency"},   iters, exp_it);
    check_output({tag, " busy_cycles"}, busy_cnt, exp_it);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] q, r, a, b;
    logic         dz;
    int           iters, busy_cnt;
    bit           saw_done;

    vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0};
    vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5};
    vecs[3] = '{8'd81,  8'd9,   8'd9,   8'd0};
    vecs[4] = '{8'd9,   8'd9,   8'd1,   8'd0};
    vecs[5] = '{8'd0,   8'd5,   8'd0,   8'd0};
    vecs[6] = '{8'd255, 8'd255, 8'd1,   8'd0};
    vecs[7] = '{8'd1,   8'd255, 8'd0,   8'd1};
    vecs[8] = '{8'd128, 8'd3,   8'd42,  8'd2};
    vecs[9] = '{8'd200, 8'd0,   8'd255, 8'd200};

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check_output("reset busy", busy, 0);
    check_output("reset done", done, 0);
    check_output("reset quotient", quotient, 0);
    check_output("reset remainder", remainder, 0);
    check_output("reset div_zero", div_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].a, vecs[i].b);
      wait_done(q, r, dz, iters, busy_cnt);
      check_output($sformatf("vec%0d quotient", i), q, vecs[i].q);
      check_output($sformatf("vec%0d remainder", i), r, vecs[i].r);
      check_output($sformatf("vec%0d div_zero", i), dz, ZERO_FAST && vecs[i].b == 0);
      check_output($sformatf("vec%0d latency", i), iters,
                   (ZERO_FAST && vecs[i].b == 0) ? 0 : W);
      @(negedge clk);
      check_output($sformatf("vec%0d done pulse", i), done, 0);
      check_output($sformatf("vec%0d quotient held", i), quotient, vecs[i].q);
    end

    // Back-to-back: the second start is raised in the done cycle of the first.
    apply_stimulus(8'd255, 8'd1);
    wait_done(q, r, dz, iters, busy_cnt);
    check_op("b2b first", 8'd255, 8'd1, q, r, dz, iters, busy_cnt);
    apply_stimulus(8'd5, 8'd9);
    wait_done(q, r, dz, iters, busy_cnt);
    check_op("b2b second", 8'd5, 8'd9, q, r, dz, iters, busy_cnt);
    @(negedge clk);

    // start with new operands at iteration 3 must not disturb the running division.
    apply_stimulus(8'd100, 8'd7);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    apply_stimulus(8'd50, 8'd5);
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'd3;
    divisor  = 8'd1;
    iters    = 3;
    while (!done && iters < 40) begin
      @(posedge clk);
      iters++;
      @(negedge clk);
    end
    check_output("ignored start quotient", quotient, 14);
    check_output("ignored start remainder", remainder, 2);
    check_output("ignored start latency", iters, W);
    @(negedge clk);

    // Asynchronous reset during iteration 4 clears everything with no result.
    apply_stimulus(8'd100, 8'd7);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("midreset busy", busy, 0);
    check_output("midreset done", done, 0);
    check_output("midreset quotient", quotient, 0);
    check_output("midreset remainder", remainder, 0);
    check_output("midreset div_zero", div_zero, 0);
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check_output("midreset no result", saw_done, 0);
    apply_stimulus(8'd81, 8'd9);
    wait_done(q, r, dz, iters, busy_cnt);
    check_op("post reset", 8'd81, 8'd9, q, r, dz, iters, busy_cnt);

    // Randomized operands, issued back to back.
    for (int i = 0; i < 150; i++) begin
      if (i % 10 == 0) begin
        a = 8'($urandom_range(1, 255));
        b = a;
      end else if (i % 10 == 1) begin
        a = 8'($urandom_range(0, 200));
        b = 8'($urandom_range(int'(a) + 1, 255));
      end else begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
      end
      apply_stimulus(a, b);
      wait_done(q, r, dz, iters, busy_cnt);
      check_op($sformatf("rand%0d %0d/%0d", i, a, b), a, b, q, r, dz, iters, busy_cnt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
